// File: rtl/stopwatch_lap.sv
// stopwatch_lap: lap-timing stopwatch built from a tick prescaler and a
// parametrised BCD digit chain. A run-control FSM handles start/stop, clear
// and lap hold, and a sticky flag records when the count overflows.
// Optional build macro: STOPWATCH_SAT_EN. When it is defined, the count
// saturates at its maximum instead of wrapping, and the stopwatch stops itself.
// When it is left undefined, the chain wraps to zero.
// Input pulses are expected to be single-cycle and already debounced.
module stopwatch_lap #(
  parameter int TICK_DIV   = 1000000,
  parameter int NUM_DIGITS = 4,
  parameter int TOP_MOD    = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_stop,
  input  logic                      clear,
  input  logic                      lap,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic                      running,
  output logic                      lap_active,
  output logic                      overflow
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    LAP_HOLD = 2'd2
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   pre_r;
  logic [DW-1:0]   count_r;
  logic [DW-1:0]   lap_r;
  logic            overflow_r;

  logic            advancing_s;
  logic            tick_s;
  logic            clear_eff_s;
  logic            lap_capture_s;
  logic            at_max_s;
  logic            sat_hit_s;
  logic [DW-1:0]   count_inc_s;

  // Largest value a digit may hold: the top digit uses TOP_MOD, the rest are decimal.
  function automatic logic [3:0] digit_max(input int idx);
    if (idx == NUM_DIGITS - 1) begin
      return 4'(TOP_MOD - 1);
    end else begin
      return 4'd9;
    end
  endfunction

  // Control qualifiers: clear only acts while stopped; lap captures only from RUNNING.
  always_comb begin
    advancing_s   = (state_r == RUNNING) || (state_r == LAP_HOLD);
    tick_s        = advancing_s && (pre_r == PRE_MAX);
    clear_eff_s   = (state_r == STOPPED) && clear;
    lap_capture_s = (state_r == RUNNING) && !start_stop && lap;
  end

  // Ripple-carry BCD increment. The carry that survives past the top digit means every digit is at its maximum.
  always_comb begin
    logic carry;
    carry       = 1'b1;
    count_inc_s = count_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_r[4*i +: 4] == digit_max(i)) begin
          count_inc_s[4*i +: 4] = 4'd0;
        end else begin
          count_inc_s[4*i +: 4] = count_r[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        count_inc_s[4*i +: 4] = count_r[4*i +: 4];
      end
    end
    at_max_s = carry;
  end

  // Saturation event: a tick at the maximum that must not wrap (saturating build only).
  always_comb begin
`ifdef STOPWATCH_SAT_EN
    sat_hit_s = tick_s && at_max_s;
`else
    sat_hit_s = 1'b0;
`endif
  end

  // Run-control FSM: clear beats start_stop, and start_stop beats lap. Saturation forces STOPPED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= STOPPED;
    end else begin
      case (state_r)
        STOPPED: begin
          if (clear) begin
            state_r <= STOPPED;
          end else if (start_stop) begin
            state_r <= RUNNING;
          end else begin
            state_r <= STOPPED;
          end
        end
        RUNNING: begin
          if (sat_hit_s) begin
            state_r <= STOPPED;
          end else if (start_stop) begin
            state_r <= STOPPED;
          end else if (lap) begin
            state_r <= LAP_HOLD;
          end else begin
            state_r <= RUNNING;
          end
        end
        LAP_HOLD: begin
          if (sat_hit_s) begin
            state_r <= STOPPED;
          end else if (start_stop) begin
            state_r <= STOPPED;
          end else if (lap) begin
            state_r <= RUNNING;
          end else begin
            state_r <= LAP_HOLD;
          end
        end
        default: begin
          state_r <= STOPPED;
        end
      endcase
    end
  end

  // Prescaler: counts only while advancing and holds otherwise, so a resumed run keeps its partial interval.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r <= '0;
    end else if (clear_eff_s) begin
      pre_r <= '0;
    end else if (advancing_s) begin
      if (pre_r == PRE_MAX) begin
        pre_r <= '0;
      end else begin
        pre_r <= pre_r + PW'(1);
      end
    end else begin
      pre_r <= pre_r;
    end
  end

  // Digit chain: advances on each tick. At the maximum it wraps to zero, or holds in the saturating build.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear_eff_s) begin
      count_r <= '0;
    end else if (tick_s) begin
`ifdef STOPWATCH_SAT_EN
      if (at_max_s) begin
        count_r <= count_r;
      end else begin
        count_r <= count_inc_s;
      end
`else
      count_r <= count_inc_s;
`endif
    end else begin
      count_r <= count_r;
    end
  end

  // Sticky overflow flag: set by a tick at the maximum and cleared only by reset or an effective clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (clear_eff_s) begin
      overflow_r <= 1'b0;
    end else if (tick_s && at_max_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Lap register: holds the count as it was just before the lap edge, for the frozen display.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_r <= '0;
    end else if (lap_capture_s) begin
      lap_r <= count_r;
    end else begin
      lap_r <= lap_r;
    end
  end

  // Output selection is decoded directly from registers, so the display has no extra cycle of delay.
  always_comb begin
    if (state_r == LAP_HOLD) begin
      digits = lap_r;
    end else begin
      digits = count_r;
    end
    running    = (state_r == RUNNING) || (state_r == LAP_HOLD);
    lap_active = (state_r == LAP_HOLD);
    overflow   = overflow_r;
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed scoreboard bench for stopwatch_lap. Instance A is 4 digits with
// TICK_DIV=4. Instance B is 2 digits with TICK_DIV=2 and exercises the wrap.
// Expected values for instance B follow the STOPWATCH_SAT_EN build setting.
module tb_stopwatch_lap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_ss, a_clr, a_lap, b_ss, b_clr, b_lap;
  logic [15:0] a_digits;
  logic        a_running, a_lapact, a_ovf;
  logic [7:0]  b_digits;
  logic        b_running, b_lapact, b_ovf;

  stopwatch_lap #(.TICK_DIV(4), .NUM_DIGITS(4), .TOP_MOD(6)) dut_a (
    .clk(clk), .reset(reset), .start_stop(a_ss), .clear(a_clr), .lap(a_lap),
    .digits(a_digits), .running(a_running), .lap_active(a_lapact), .overflow(a_ovf)
  );

  stopwatch_lap #(.TICK_DIV(2), .NUM_DIGITS(2), .TOP_MOD(6)) dut_b (
    .clk(clk), .reset(reset), .start_stop(b_ss), .clear(b_clr), .lap(b_lap),
    .digits(b_digits), .running(b_running), .lap_active(b_lapact), .overflow(b_ovf)
  );

  typedef struct {
    bit          sel;
    string       name;
    logic [15:0] d;
    logic        run;
    logic        lapa;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(string n, string f, logic [15:0] act, logic [15:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s.%s actual=%0h expected=%0h", n, f, act, ex);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares it on the falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      if (mon_e.sel == 1'b0) begin
        cmp(mon_e.name, "digits", a_digits, mon_e.d);
        cmp(mon_e.name, "running", {15'd0, a_running}, {15'd0, mon_e.run});
        cmp(mon_e.name, "lap_active", {15'd0, a_lapact}, {15'd0, mon_e.lapa});
        cmp(mon_e.name, "overflow", {15'd0, a_ovf}, {15'd0, mon_e.ovf});
      end else begin
        cmp(mon_e.name, "digits", {8'd0, b_digits}, mon_e.d);
        cmp(mon_e.name, "running", {15'd0, b_running}, {15'd0, mon_e.run});
        cmp(mon_e.name, "lap_active", {15'd0, b_lapact}, {15'd0, mon_e.lapa});
        cmp(mon_e.name, "overflow", {15'd0, b_ovf}, {15'd0, mon_e.ovf});
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle pulse on the chosen instance. Returns just after the edge that sampled it.
  task automatic drive(bit sel, bit ss, bit clr, bit lp);
    if (sel == 1'b0) begin
      a_ss = ss; a_clr = clr; a_lap = lp;
    end else begin
      b_ss = ss; b_clr = clr; b_lap = lp;
    end
    step(1);
    a_ss = 1'b0; a_clr = 1'b0; a_lap = 1'b0;
    b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
  endtask

  task automatic exp_out(bit sel, string name, logic [15:0] d, logic run, logic lapa, logic ovf);
    exp_t e;
    e.sel = sel; e.name = name; e.d = d; e.run = run; e.lapa = lapa; e.ovf = ovf;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_ss = 1'b0; a_clr = 1'b0; a_lap = 1'b0;
    b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
    step(2);
    reset = 1'b0;
    exp_out(1'b0, "reset_a", 16'h0000, 1'b0, 1'b0, 1'b0);
    exp_out(1'b1, "reset_b", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Plain run: 40 cycles at TICK_DIV=4 give ten ticks.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step(40);
    exp_out(1'b0, "run40", 16'h0010, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out(1'b0, "stop40", 16'h0010, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out(1'b0, "clear40", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Pause/resume: stop on the 6th cycle (prescaler=2), then resume; the next tick comes 2 cycles later.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step(5);
    exp_out(1'b0, "run5", 16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out(1'b0, "paused", 16'h0001, 1'b0, 1'b0, 1'b0);
    step(20);
    exp_out(1'b0, "paused20", 16'h0001, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out(1'b0, "resumed", 16'h0001, 1'b1, 1'b0, 1'b0);
    step(1);
    exp_out(1'b0, "resume_p1", 16'h0001, 1'b1, 1'b0, 1'b0);
    step(1);
    exp_out(1'b0, "resume_p2", 16'h0002, 1'b1, 1'b0, 1'b0);

    // Lap: freeze at 5 while the count keeps running underneath, then release to the live value 8.
    step(12);
    exp_out(1'b0, "at5", 16'h0005, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out(1'b0, "lap_on", 16'h0005, 1'b1, 1'b1, 1'b0);
    step(12);
    exp_out(1'b0, "lap_frozen", 16'h0005, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out(1'b0, "lap_off", 16'h0008, 1'b1, 1'b0, 1'b0);

    // Clear rules: ignored while running; effective while stopped; beats start_stop in the same cycle.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out(1'b0, "clr_running", 16'h0008, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    exp_out(1'b0, "stop_tick", 16'h0009, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    exp_out(1'b0, "clr_stopped", 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    exp_out(1'b0, "clr_and_ss", 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out(1'b0, "lap_stopped", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset during LAP_HOLD with start_stop also asserted.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step(4);
    exp_out(1'b0, "pre_lap", 16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp_out(1'b0, "lap_hold", 16'h0001, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    a_ss  = 1'b1;
    step(1);
    reset = 1'b0;
    a_ss  = 1'b0;
    exp_out(1'b0, "mid_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step(3);
    exp_out(1'b0, "post_rst3", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1);
    exp_out(1'b0, "post_rst4", 16'h0001, 1'b1, 1'b0, 1'b0);

    // Wrap on a 2-digit chain (max 59): 60 ticks in 120 cycles.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step(118);
    exp_out(1'b1, "b_at59", 16'h0059, 1'b1, 1'b0, 1'b0);
    step(2);
`ifdef STOPWATCH_SAT_EN
    exp_out(1'b1, "b_sat", 16'h0059, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(1'b1, "b_restart", 16'h0059, 1'b1, 1'b0, 1'b1);
    step(2);
    exp_out(1'b1, "b_sat_again", 16'h0059, 1'b0, 1'b0, 1'b1);
`else
    exp_out(1'b1, "b_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    step(2);
    exp_out(1'b1, "b_after_wrap", 16'h0001, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_out(1'b1, "b_stop", 16'h0001, 1'b0, 1'b0, 1'b1);
`endif
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    exp_out(1'b1, "b_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
